linear_credit_queue: RTL

- Parametrised successor of the read-path linear buffer: credit-gated reservation front end plus a shift-register FIFO of allocated SRAM linear base addresses and config ids.
- Sits between the accumulator's mofs stream, the SRAM write collector's done_linear output and the warp looper.
- Generalises the fixed 3-entry buffer to DEPTH entries, with configurable linear and id widths.
- Adds a head look-ahead window, occupancy and credit outputs, synchronous flush, and sticky protocol-error flags.

---
 rtl/linear_credit_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/linear_credit_queue.sv
// Credit-gated reservation front end feeding a shift-register FIFO of SRAM linear
// base addresses and config ids, with a head look-ahead window and sticky error flags.
module linear_credit_queue #(
  parameter int LBW   = 16,
  parameter int IDBW  = 3,
  parameter int DEPTH = 3,
  parameter int WIN   = 2,
  parameter int CBW   = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  res_rdy,
  output logic                  res_ack,
  output logic                  resf_rdy,
  input  logic                  resf_ack,
  input  logic                  push_rdy,
  output logic                  push_ack,
  input  logic [LBW-1:0]        i_push_linear,
  input  logic [IDBW-1:0]       i_push_id,
  output logic                  pop_rdy,
  input  logic                  pop_ack,
  output logic [WIN*LBW-1:0]    o_linear,
  output logic [WIN*IDBW-1:0]   o_id,
  output logic [WIN-1:0]        o_wvalid,
  output logic [CBW-1:0]        o_count,
  output logic [CBW-1:0]        o_credit,
  output logic                  o_full,
  input  logic                  i_flush,
  output logic [1:0]            o_err
);

  logic [CBW-1:0]        countQ, countD;
  logic [CBW-1:0]        creditQ, creditD;
  logic [DEPTH*LBW-1:0]  linQ, linD;
  logic [DEPTH*IDBW-1:0] idQ, idD;
  logic [1:0]            errQ, errD;
  logic                  resFire, pushFire, popFire;
  logic [CBW-1:0]        tailIdx;

  assign o_full   = (creditQ == CBW'(DEPTH));
  assign resf_rdy = res_rdy && !o_full && !i_flush;
  assign res_ack  = resf_ack && resf_rdy;
  assign pop_rdy  = (countQ != '0) && !i_flush;
  assign push_ack = push_rdy && (countQ < CBW'(DEPTH)) && !i_flush;

  assign resFire  = res_ack;
  assign pushFire = push_ack;
  assign popFire  = pop_rdy && pop_ack;
  assign tailIdx  = countQ - CBW'(popFire);

  // Pop shifts every slot one step toward the head; the top slot keeps its stale value.
  always_comb begin
    linD = linQ;
    idD  = idQ;
    if (popFire) begin
      linD = {linQ[DEPTH*LBW-1 -: LBW], linQ[DEPTH*LBW-1:LBW]};
      idD  = {idQ[DEPTH*IDBW-1 -: IDBW], idQ[DEPTH*IDBW-1:IDBW]};
    end
    if (pushFire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CBW'(i) == tailIdx) begin
          linD[i*LBW +: LBW]  = i_push_linear;
          idD[i*IDBW +: IDBW] = i_push_id;
        end
      end
    end
  end

  always_comb begin
    countD  = countQ + CBW'(pushFire) - CBW'(popFire);
    creditD = creditQ;
    if (resFire && !popFire)
      creditD = creditQ + CBW'(1);
    else if (!resFire && popFire && (creditQ != '0))
      creditD = creditQ - CBW'(1);
    if (i_flush) begin
      countD  = '0;
      creditD = '0;
    end
    errD = errQ | {push_rdy && (countQ >= creditQ), pop_ack && !pop_rdy};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      countQ  <= '0;
      creditQ <= '0;
      linQ    <= '0;
      idQ     <= '0;
      errQ    <= '0;
    end else begin
      countQ  <= countD;
      creditQ <= creditD;
      linQ    <= linD;
      idQ     <= idD;
      errQ    <= errD;
    end
  end

  assign o_linear = linQ[WIN*LBW-1:0];
  assign o_id     = idQ[WIN*IDBW-1:0];
  assign o_count  = countQ;
  assign o_credit = creditQ;
  assign o_err    = errQ;

  for (genvar k = 0; k < WIN; k++) begin : gWvalid
    assign o_wvalid[k] = (CBW'(k) < countQ);
  end

endmodule
